// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory write path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package imem_loader_pkg;

  // Bytes carried by one instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Little-endian lane select: lane 0 is bits [7:0] and lands at the lowest
  // byte address. The fetch side uses the same definition, so both ends of
  // the memory agree on byte order.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// Holds one instruction word and presents it one byte lane at a time.
// Latency: lane_data reflects a load on the cycle after load is sampled.
// Backpressure: none internally; the owning FSM decides when to load/advance.
module imem_word_serializer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        advance,
  output logic [1:0]  byte_idx,
  output logic [7:0]  lane_data,
  output logic        last
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Word register and byte index: a load restarts at lane 0 and has priority
  // over advance so a back-to-back word replaces the finished one cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= load_data;
      idx_q  <= '0;
    end else if (advance) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

  assign byte_idx  = idx_q;
  assign lane_data = byte_lane(word_q, idx_q);
  assign last      = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Preloads the byte-addressed instruction memory from a 32-bit word stream.
// Latency: start to first byte write 2 cycles with word_valid high; last write to done 1 cycle.
// Backpressure: word_ready only in FETCH or on the final byte of a word with more words due.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The end address is formed two bits wider than the address so that even
  // the largest base plus the largest count cannot wrap and sneak past the
  // bounds check.
  localparam int SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] MEM_BYTES = {2'b01, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              error_q;

  logic [SUM_W-1:0]  end_addr;
  logic              misaligned;
  logic              out_of_range;
  logic              rejected;
  logic              take_start;

  logic              ser_load;
  logic              ser_advance;
  logic              word_end;
  logic [1:0]        ser_idx;
  logic [7:0]        ser_byte;
  logic              ser_last;

  // Request validation, evaluated against the live inputs while idle.
  assign end_addr     = {2'b00, base_addr} +
                        ({{(SUM_W-CNT_W){1'b0}}, word_count} << 2);
  assign misaligned   = |base_addr[1:0];
  assign out_of_range = end_addr > MEM_BYTES;
  assign rejected     = misaligned | out_of_range;
  assign take_start   = (state == ST_IDLE) && start;

  imem_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (word_data),
    .advance   (ser_advance),
    .byte_idx  (ser_idx),
    .lane_data (ser_byte),
    .last      (ser_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the handshake and serializer strobes it implies.
  always_comb begin
    state_nxt   = state;
    word_ready  = 1'b0;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    word_end    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (rejected || (word_count == '0)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load  = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ser_last) begin
          word_end = 1'b1;
          if (remaining != CNT_W'(1)) begin
            // Offer the next word on the final byte so a ready source
            // streams at one word every four cycles without a bubble.
            word_ready = 1'b1;
            if (word_valid) begin
              ser_load = 1'b1;
            end else begin
              state_nxt = ST_FETCH;
            end
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          ser_advance = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Load parameters and sticky error: parameters are captured only from an
  // idle start, then walk forward one word at a time on each final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      error_q   <= 1'b0;
    end else if (take_start) begin
      cur_addr  <= base_addr;
      remaining <= word_count;
      error_q   <= rejected;
    end else if (word_end) begin
      cur_addr  <= cur_addr + ADDR_W'(BYTES_PER_WORD);
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Memory-side outputs decode from registered state and the stored word
  // only, so nothing from word_data reaches the write port in the same cycle.
  assign mem_we    = (state == ST_WRITE);
  assign mem_waddr = cur_addr + {{(ADDR_W-2){1'b0}}, ser_idx};
  assign mem_wdata = ser_byte;
  assign busy      = (state == ST_FETCH) || (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte order, streaming, stalls, bounds, reset.
// Latency: checks start-to-write and write-to-done cycle distances.
// Backpressure: exercises word_valid gaps and back-to-back words.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  // Event log filled by the monitor.
  int   cyc = 0;
  int   nw = 0;
  int   wa [64];
  int   wd [64];
  int   wc [64];
  int   nrdy = 0;
  int   nhs = 0;
  int   nbusy = 0;
  int   ndone = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;

  imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge, so the falling edge sees a
  // stable picture of each cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we && nw < 64) begin
      wa[nw] = int'(mem_waddr);
      wd[nw] = int'(mem_wdata);
      wc[nw] = cyc;
      nw = nw + 1;
    end
    if (word_ready) nrdy = nrdy + 1;
    if (word_ready && word_valid) nhs = nhs + 1;
    if (busy) nbusy = nbusy + 1;
    if (done) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
    if (start) start_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents words in order; gap inserts idle cycles on word_valid between words.
  task automatic send_words(input string tag, input logic [3:0][31:0] ws,
                            input int n, input int gap);
    bit ok;
    for (int k = 0; k < n; k++) begin
      word_data = ws[k];
      word_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (word_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk($sformatf("%s hs%0d", tag, k), 32'(ok), 32'd1);
      @(posedge clk); #1;
      if (gap > 0 && k < n - 1) begin
        word_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  // exp_addr/exp_data are the hand-derived byte writes in issue order.
  task automatic check_writes(input string tag, input int first, input int n,
                              input logic [11:0][7:0] exp_addr,
                              input logic [11:0][7:0] exp_data,
                              input bit contiguous);
    chk({tag, " nwrites"}, 32'(nw - first), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr%0d", tag, i), 32'(wa[first+i]), 32'(exp_addr[i]));
      chk($sformatf("%s data%0d", tag, i), 32'(wd[first+i]), 32'(exp_data[i]));
      if (contiguous)
        chk($sformatf("%s cyc%0d", tag, i), 32'(wc[first+i] - wc[first]), 32'(i));
    end
  endtask

  int w0, h0, d0, b0, r0;
  bit found;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    word_valid = 1'b0;
    word_data = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst word_ready", 32'(word_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle busy", 32'(busy), 32'd0);

    // Single word, little-endian lanes, latencies.
    w0 = nw; h0 = nhs;
    do_start(8'h10, 7'd1);
    send_words("t1", {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 1, 0);
    wait_done("t1", 20);
    check_writes("t1", w0, 4, {8'h13, 8'h12, 8'h11, 8'h10},
                 {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1);
    chk("t1 start_to_we", 32'(wc[w0] - start_cyc), 32'd2);
    chk("t1 we_to_done", 32'(done_cyc - wc[w0+3]), 32'd1);
    chk("t1 error", 32'(error), 32'd0);
    chk("t1 handshakes", 32'(nhs - h0), 32'd1);

    // Three words streamed with no bubbles.
    w0 = nw; h0 = nhs; r0 = nrdy;
    do_start(8'h00, 7'd3);
    send_words("t2", {32'h0, 32'h33333333, 32'h22222222, 32'h11111111}, 3, 0);
    wait_done("t2", 30);
    check_writes("t2", w0, 12,
                 {8'h0B, 8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                  8'h03, 8'h02, 8'h01, 8'h00},
                 {8'h33, 8'h33, 8'h33, 8'h33, 8'h22, 8'h22, 8'h22, 8'h22,
                  8'h11, 8'h11, 8'h11, 8'h11}, 1'b1);
    chk("t2 handshakes", 32'(nhs - h0), 32'd3);
    chk("t2 ready_pulses", 32'(nrdy - r0), 32'd3);
    chk("t2 we_to_done", 32'(done_cyc - wc[w0+11]), 32'd1);

    // Two words with a five-cycle source gap: writes pause in FETCH.
    w0 = nw; b0 = nbusy;
    do_start(8'h20, 7'd2);
    send_words("t3", {32'h0, 32'h0, 32'h87654321, 32'hA5B6C7D8}, 2, 5);
    wait_done("t3", 40);
    check_writes("t3", w0, 8,
                 {8'h0, 8'h0, 8'h0, 8'h0,
                  8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20},
                 {8'h0, 8'h0, 8'h0, 8'h0,
                  8'h87, 8'h65, 8'h43, 8'h21, 8'hA5, 8'hB6, 8'hC7, 8'hD8}, 1'b0);
    chk("t3 pause", 32'(wc[w0+4] - wc[w0+3]), 32'd3);
    chk("t3 start_to_done", 32'(done_cyc - start_cyc), 32'd12);
    chk("t3 busy_cycles", 32'(nbusy - b0), 32'd11);

    // Misaligned base is rejected.
    w0 = nw; b0 = nbusy; d0 = ndone;
    do_start(8'h02, 7'd1);
    wait_done("t4", 10);
    chk("t4 error", 32'(error), 32'd1);
    chk("t4 nwrites", 32'(nw - w0), 32'd0);
    chk("t4 busy_cycles", 32'(nbusy - b0), 32'd0);
    chk("t4 done_pulses", 32'(ndone - d0), 32'd1);

    // Exactly fills the top of memory; the accepted start clears error.
    w0 = nw;
    do_start(8'hFC, 7'd1);
    chk("t5 error_cleared", 32'(error), 32'd0);
    send_words("t5", {32'h0, 32'h0, 32'h0, 32'h44332211}, 1, 0);
    wait_done("t5", 20);
    check_writes("t5", w0, 4, {8'hFF, 8'hFE, 8'hFD, 8'hFC},
                 {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
    chk("t5 error", 32'(error), 32'd0);

    // One word past the top of memory is rejected.
    w0 = nw;
    do_start(8'hFC, 7'd2);
    wait_done("t6", 10);
    chk("t6 error", 32'(error), 32'd1);
    chk("t6 nwrites", 32'(nw - w0), 32'd0);

    // Zero-length load is legal.
    w0 = nw; d0 = ndone;
    do_start(8'h20, 7'd0);
    wait_done("t7", 10);
    chk("t7 error", 32'(error), 32'd0);
    chk("t7 nwrites", 32'(nw - w0), 32'd0);
    chk("t7 done_pulses", 32'(ndone - d0), 32'd1);

    // A second start while loading is ignored.
    w0 = nw; h0 = nhs; d0 = ndone;
    do_start(8'h40, 7'd2);
    fork
      send_words("t8", {32'h0, 32'h0, 32'hB3B2B1B0, 32'hA3A2A1A0}, 2, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 8'h80;
        word_count = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done("t8", 30);
    repeat (6) @(posedge clk);
    #1;
    check_writes("t8", w0, 8,
                 {8'h0, 8'h0, 8'h0, 8'h0,
                  8'h47, 8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h40},
                 {8'h0, 8'h0, 8'h0, 8'h0,
                  8'hB3, 8'hB2, 8'hB1, 8'hB0, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    chk("t8 handshakes", 32'(nhs - h0), 32'd2);
    chk("t8 done_pulses", 32'(ndone - d0), 32'd1);
    chk("t8 busy_after", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a word.
    do_start(8'h30, 7'd2);
    word_data = 32'hC3C2C1C0;
    word_valid = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (mem_we && mem_waddr == 8'h32) begin
        found = 1'b1;
        break;
      end
    end
    chk("t9 reached_byte2", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t9 rst mem_we", 32'(mem_we), 32'd0);
    chk("t9 rst busy", 32'(busy), 32'd0);
    chk("t9 rst word_ready", 32'(word_ready), 32'd0);
    word_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t9 idle busy", 32'(busy), 32'd0);
    chk("t9 idle done", 32'(done), 32'd0);
    w0 = nw;
    do_start(8'h50, 7'd1);
    send_words("t9", {32'h0, 32'h0, 32'h0, 32'h5A6B7C8D}, 1, 0);
    wait_done("t9", 20);
    check_writes("t9", w0, 4, {8'h53, 8'h52, 8'h51, 8'h50},
                 {8'h5A, 8'h6B, 8'h7C, 8'h8D}, 1'b1);
    chk("t9 error", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
